// File: rtl/dbg_run_ctrl.sv
// Run/halt/step and register-dump controller for the pipelined CPU.
// Optional breakpoint comparator is enabled by defining DBG_BREAKPOINT_EN.
module dbg_run_ctrl #(
  parameter int DRAIN_CYCLES = 5,
  parameter int MAX_CYCLES   = 100,
  parameter int NREG         = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        resume_req,
  input  logic        dump_req,
`ifdef DBG_BREAKPOINT_EN
  input  logic [31:0] pc_in,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
`endif
  output logic        fetch_en,
  output logic        cpu_en,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        halted,
  output logic [31:0] cycle_cnt
);

  localparam int              DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [31:0]     WD_LAST    = 32'(MAX_CYCLES - 1);
  localparam logic [4:0]      LAST_IDX   = 5'(NREG - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_STEP,
    S_DUMP_SEL,
    S_DUMP_OUT
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [4:0]    idx_nxt, sel_nxt;
  logic [31:0]   data_nxt;
  logic          valid_nxt, done_nxt;
  logic          fetch_nxt, cpu_nxt, halted_nxt;
  logic          wd_hit, bp_hit;

  assign wd_hit = (MAX_CYCLES != 0) && (cycle_cnt == WD_LAST);

`ifdef DBG_BREAKPOINT_EN
  // Masks the match for one RUN cycle after resume so execution can leave the breakpoint.
  logic resumed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) resumed <= 1'b0;
    else     resumed <= (state == S_HALTED) && (state_nxt == S_RUN);
  end

  assign bp_hit = bp_en && (pc_in == bp_addr) && !resumed;
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    idx_nxt   = dump_idx;
    sel_nxt   = reg_sel;
    data_nxt  = dump_data;
    valid_nxt = dump_valid;
    done_nxt  = 1'b0;
    case (state)
      S_RUN: begin
        if (halt_req || wd_hit || bp_hit) begin
          state_nxt = S_DRAIN;
          drain_nxt = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        drain_nxt = drain_cnt - 1'b1;
        if (drain_cnt <= 1) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (dump_req) begin
          state_nxt = S_DUMP_SEL;
          idx_nxt   = '0;
          sel_nxt   = '0;
        end else if (step_req) begin
          state_nxt = S_STEP;
        end else if (resume_req) begin
          state_nxt = S_RUN;
        end
      end
      S_STEP: begin
        state_nxt = S_DRAIN;
        drain_nxt = DRAIN_LOAD;
      end
      S_DUMP_SEL: begin
        data_nxt  = reg_data;
        valid_nxt = 1'b1;
        state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (dump_ready) begin
          valid_nxt = 1'b0;
          if (dump_idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            idx_nxt   = '0;
            sel_nxt   = '0;
            state_nxt = S_HALTED;
          end else begin
            idx_nxt   = dump_idx + 5'd1;
            sel_nxt   = dump_idx + 5'd1;
            state_nxt = S_DUMP_SEL;
          end
        end
      end
      default: state_nxt = S_RUN;
    endcase

    fetch_nxt  = 1'b0;
    cpu_nxt    = 1'b0;
    halted_nxt = 1'b0;
    case (state_nxt)
      S_RUN, S_STEP: begin
        fetch_nxt = 1'b1;
        cpu_nxt   = 1'b1;
      end
      S_DRAIN:                          cpu_nxt    = 1'b1;
      S_HALTED, S_DUMP_SEL, S_DUMP_OUT: halted_nxt = 1'b1;
      default: begin
        fetch_nxt = 1'b1;
        cpu_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      drain_cnt  <= '0;
      fetch_en   <= 1'b1;
      cpu_en     <= 1'b1;
      halted     <= 1'b0;
      reg_sel    <= '0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_nxt;
      fetch_en   <= fetch_nxt;
      cpu_en     <= cpu_nxt;
      halted     <= halted_nxt;
      reg_sel    <= sel_nxt;
      dump_idx   <= idx_nxt;
      dump_data  <= data_nxt;
      dump_valid <= valid_nxt;
      dump_done  <= done_nxt;
      if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Self-checking bench for dbg_run_ctrl: vector table, dump sequences,
// randomized operations against an operation-level model, and async reset mid-dump.
module tb_dbg_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_req = 1'b0, step_req = 1'b0, resume_req = 1'b0, dump_req = 1'b0;
  logic        dump_ready = 1'b0;
  logic        fetch_en, cpu_en, dump_valid, dump_done, halted;
  logic [4:0]  reg_sel, dump_idx;
  logic [31:0] reg_data, dump_data, cycle_cnt;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;
  int n_fetch = 0, n_run = 0, n_done = 0;
  logic [36:0] beats [$];
  logic        stall_prev = 1'b0;
  logic [4:0]  p_idx;
  logic [31:0] p_data;

  assign reg_data = rf[reg_sel];

  dbg_run_ctrl #(.DRAIN_CYCLES(5), .MAX_CYCLES(100), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req), .dump_req(dump_req),
    .fetch_en(fetch_en), .cpu_en(cpu_en),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
    .halted(halted), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // Observer: counts run/fetch cycles, done pulses, collects accepted beats, checks beat stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (fetch_en) n_fetch++;
      if (!halted) n_run++;
      if (dump_done) n_done++;
      if (stall_prev) begin
        check("hold_valid", 64'(dump_valid), 64'd1);
        check("hold_idx", 64'(dump_idx), 64'(p_idx));
        check("hold_data", 64'(dump_data), 64'(p_data));
      end
      if (dump_valid && dump_ready) beats.push_back({dump_idx, dump_data});
      stall_prev = dump_valid && !dump_ready;
      p_idx  = dump_idx;
      p_data = dump_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    halt_req = 1'b0; step_req = 1'b0; resume_req = 1'b0; dump_req = 1'b0;
  endtask

  task automatic clear_counts();
    n_fetch = 0; n_run = 0; n_done = 0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_fetch"}, 64'(fetch_en), 64'd1);
    check({nm, "_cpu"}, 64'(cpu_en), 64'd1);
    check({nm, "_sel"}, 64'(reg_sel), 64'd0);
    check({nm, "_valid"}, 64'(dump_valid), 64'd0);
    check({nm, "_idx"}, 64'(dump_idx), 64'd0);
    check({nm, "_data"}, 64'(dump_data), 64'd0);
    check({nm, "_done"}, 64'(dump_done), 64'd0);
    check({nm, "_halted"}, 64'(halted), 64'd0);
    check({nm, "_cnt"}, 64'(cycle_cnt), 64'd0);
  endtask

  task automatic wait_halted(input string nm);
    int n = 0;
    while (!halted && n < 500) begin
      tick();
      n++;
    end
    if (!halted) check({nm, "_timeout"}, 64'(halted), 64'd1);
  endtask

  // mode 0: ready always high; 1: ready toggles every 3 cycles; 2: random ready.
  task automatic run_dump(input int mode, input logic also_step, input logic also_resume, input string nm);
    logic [31:0] c0;
    int n;
    c0 = cycle_cnt;
    beats.delete();
    clear_counts();
    dump_ready = (mode == 0);
    dump_req = 1'b1; step_req = also_step; resume_req = also_resume;
    tick();
    clear_reqs();
    n = 0;
    while (!dump_done && n < 2000) begin
      if (mode == 1) dump_ready = (n % 6) >= 3;
      else if (mode == 2) dump_ready = ($urandom_range(0, 2) != 0);
      tick();
      n++;
    end
    check({nm, "_done_seen"}, 64'(dump_done), 64'd1);
    if (mode == 0) check({nm, "_len"}, 64'(n), 64'd64);
    dump_ready = 1'b0;
    tick();
    check({nm, "_done_pulses"}, 64'(n_done), 64'd1);
    check({nm, "_done_low"}, 64'(dump_done), 64'd0);
    check({nm, "_nbeats"}, 64'(beats.size()), 64'd32);
    for (int i = 0; i < 32 && i < beats.size(); i++)
      check({nm, "_beat"}, 64'(beats[i]), 64'({5'(i), rf[i]}));
    check({nm, "_halted"}, 64'(halted), 64'd1);
    check({nm, "_cnt"}, 64'(cycle_cnt), 64'(c0));
    check({nm, "_run_cycles"}, 64'(n_run), 64'd0);
  endtask

  typedef struct {
    logic        halt, step, resume;
    int          cyc;
    logic        fetch, cpu, hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt [17];

  initial begin
    logic [31:0] c0;
    int k, op;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 99, 1'b1, 1'b1, 1'b0, 32'd99};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 32'd100};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 32'd104};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 32'd105};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b1, 32'd105};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 32'd105};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 32'd115};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 32'd116};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 32'd120};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 32'd121};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 32'd121};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 32'd122};
    vt[12] = '{1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0, 32'd126};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 32'd127};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 32'd127};
    vt[15] = '{1'b0, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b1, 32'd133};
    vt[16] = '{1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 32'd133};

    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;

    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    #5 rst = 1'b0;

    // Watchdog, halt with ignored re-request, step, priority step over resume.
    for (int v = 0; v < 17; v++) begin
      halt_req = vt[v].halt; step_req = vt[v].step; resume_req = vt[v].resume;
      repeat (vt[v].cyc) tick();
      clear_reqs();
      check($sformatf("vec%0d_fetch", v), 64'(fetch_en), 64'(vt[v].fetch));
      check($sformatf("vec%0d_cpu", v), 64'(cpu_en), 64'(vt[v].cpu));
      check($sformatf("vec%0d_halted", v), 64'(halted), 64'(vt[v].hlt));
      check($sformatf("vec%0d_cnt", v), 64'(cycle_cnt), 64'(vt[v].cnt));
    end

    run_dump(0, 1'b1, 1'b0, "dump_fast");
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    run_dump(1, 1'b0, 1'b0, "dump_toggle");

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      c0 = cycle_cnt;
      clear_counts();
      if (op == 0) begin
        step_req = 1'b1; resume_req = 1'($urandom_range(0, 1));
        tick();
        clear_reqs();
        wait_halted("rnd_step");
        check("rnd_step_cnt", 64'(cycle_cnt), 64'(c0 + 32'd6));
        check("rnd_step_fetch", 64'(n_fetch), 64'd1);
        check("rnd_step_run", 64'(n_run), 64'd6);
      end else if (op == 1) begin
        k = $urandom_range(1, 20);
        resume_req = 1'b1;
        tick();
        for (int j = 0; j < k; j++) begin
          resume_req = 1'($urandom_range(0, 1));
          step_req   = 1'($urandom_range(0, 1));
          dump_req   = 1'($urandom_range(0, 1));
          tick();
        end
        clear_reqs();
        halt_req = 1'b1;
        tick();
        clear_reqs();
        wait_halted("rnd_run");
        check("rnd_run_cnt", 64'(cycle_cnt), 64'(c0 + 32'(k) + 32'd6));
        check("rnd_run_fetch", 64'(n_fetch), 64'(k + 1));
        check("rnd_run_run", 64'(n_run), 64'(k + 6));
      end else begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_dump");
      end
    end

    // Asynchronous reset in the middle of a dump.
    rf[10] = 32'hDEADBEEF;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    clear_reqs();
    k = 0;
    while (!(dump_valid && dump_idx == 5'd10) && k < 200) begin
      tick();
      k++;
    end
    dump_ready = 1'b0;
    check("mid_dump_idx", 64'(dump_idx), 64'd10);
    check("mid_dump_valid", 64'(dump_valid), 64'd1);
    #3 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    #2 rst = 1'b0;
    repeat (3) tick();
    check("post_rst_cnt", 64'(cycle_cnt), 64'd3);
    check("post_rst_fetch", 64'(fetch_en), 64'd1);
    check("post_rst_halted", 64'(halted), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
